// File: rtl/mdu_pkg.sv
// mdu_pkg: MDU funct3 codes, completion-queue entry type and architectural result select
package mdu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } mdu_entry_t;

    // funct3[2] splits MUL from DIV; funct3[1] then picks remainder over quotient
    function automatic logic [XLEN-1:0] mdu_select(
        input logic [2:0]      funct3,
        input logic [63:0]     product,
        input logic [XLEN-1:0] quot,
        input logic [XLEN-1:0] rem
    );
        return funct3[2] ? (funct3[1] ? rem : quot)
                         : (funct3 == F3_MUL ? product[31:0] : product[63:32]);
    endfunction

endpackage

// File: rtl/mdu_cq.sv
// mdu_cq: in-order completion FIFO, two writes and one read per cycle, with occupancy
module mdu_cq
    import mdu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we0,
    input  mdu_entry_t             wd0,
    input  logic                   we1,
    input  mdu_entry_t             wd1,
    input  logic                   re,
    output mdu_entry_t             head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    mdu_entry_t  mem [DEPTH];
    logic [AW:0] wptr, rptr, wnext;

    // extra pointer MSB tells full from empty when the index bits match
    assign wnext = wptr + (AW+1)'(1);
    assign head  = mem[rptr[AW-1:0]];
    assign empty = wptr == rptr;
    assign count = wptr - rptr;

    always_ff @(posedge clk) begin
        if (we0) mem[wptr[AW-1:0]] <= wd0;
        if (we1) mem[wnext[AW-1:0]] <= wd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + (AW+1)'(we0) + (AW+1)'(we1);
            rptr <= rptr + (AW+1)'(re);
        end
    end

endmodule

// File: rtl/mdu_wb_arbiter.sv
// mdu_wb_arbiter: merges MUL/DIV completions with pipeline writeback onto the single RF write port
module mdu_wb_arbiter
    import mdu_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mul_done_valid,
    input  logic [2:0]            mul_done_funct3,
    input  logic [4:0]            mul_done_rd,
    input  logic [63:0]           mul_product,
    input  logic                  div_done_valid,
    input  logic [2:0]            div_done_funct3,
    input  logic [4:0]            div_done_rd,
    input  logic [31:0]           div_quot,
    input  logic [31:0]           div_rem,
    input  logic                  pipe_wb_en,
    input  logic [4:0]            pipe_wb_rd,
    input  logic [DATA_WIDTH-1:0] pipe_wb_data,
    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  busy_clr_valid,
    output logic [4:0]            busy_clr_rd,
    output logic                  mdu_stall,
    output logic                  pipe_hold,
    output logic                  err_overflow
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    mdu_entry_t    mul_e, div_e, head, wd0;
    logic [CW-1:0] count;
    logic [CW:0]   free, occ_next;
    logic [SW-1:0] starve;
    logic          empty, mv, dv, byp_ok, byp_m, byp_d, cand_m, cand_d;
    logic          keep_m, keep_d, deq, drop, we0, we1;

    assign mv    = mul_done_valid && mul_done_rd != 5'd0;
    assign dv    = div_done_valid && div_done_rd != 5'd0;
    assign mul_e = '{rd: mul_done_rd, data: mdu_select(mul_done_funct3, mul_product, div_quot, div_rem)};
    assign div_e = '{rd: div_done_rd, data: mdu_select(div_done_funct3, mul_product, div_quot, div_rem)};

    mdu_cq #(.DEPTH(DEPTH)) u_cq (
        .clk   (clk),
        .rst   (rst),
        .we0   (we0),
        .wd0   (wd0),
        .we1   (we1),
        .wd1   (div_e),
        .re    (deq),
        .head  (head),
        .empty (empty),
        .count (count)
    );

    // MDU-sourced writes are masked during reset so flushed entries never clear the scoreboard
    always_comb begin
        byp_ok         = !rst && !pipe_wb_en && empty;
        byp_m          = byp_ok && mv;
        byp_d          = byp_ok && !mv && dv;
        deq            = !rst && !pipe_wb_en && !empty;
        cand_m         = mv && !byp_m;
        cand_d         = dv && !byp_d;
        free           = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(deq);
        keep_m         = cand_m && free != '0;
        keep_d         = cand_d && free > (CW+1)'(keep_m);
        drop           = (cand_m && !keep_m) || (cand_d && !keep_d);
        we0            = keep_m || keep_d;
        we1            = keep_m && keep_d;
        wd0            = keep_m ? mul_e : div_e;
        occ_next       = {1'b0, count} + (CW+1)'(we0) + (CW+1)'(we1) - (CW+1)'(deq);
        rf_we          = pipe_wb_en || deq || byp_m || byp_d;
        busy_clr_valid = deq || byp_m || byp_d;
        busy_clr_rd    = deq ? head.rd : byp_m ? mul_e.rd : byp_d ? div_e.rd : 5'd0;
        rf_waddr       = pipe_wb_en ? pipe_wb_rd : busy_clr_rd;
        rf_wdata       = pipe_wb_en ? pipe_wb_data
                       : deq ? head.data : byp_m ? mul_e.data : byp_d ? div_e.data : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mdu_stall    <= 1'b0;
            pipe_hold    <= 1'b0;
            err_overflow <= 1'b0;
            starve       <= '0;
        end else begin
            mdu_stall    <= occ_next >= (CW+1)'(DEPTH - 1);
            err_overflow <= err_overflow || drop;
            pipe_hold    <= 1'b0;
            if (empty || deq) begin
                starve <= '0;
            end else if (pipe_wb_en) begin
                if (starve == SW'(STARVE_LIMIT - 1)) begin
                    starve    <= '0;
                    pipe_hold <= 1'b1;
                end else begin
                    starve <= starve + SW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_wb_arbiter.sv
// tb_mdu_wb_arbiter: directed scenarios plus randomized traffic against a queue-based reference model
module tb_mdu_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mul_done_valid, div_done_valid, pipe_wb_en;
    logic [2:0]  mul_done_funct3, div_done_funct3;
    logic [4:0]  mul_done_rd, div_done_rd, pipe_wb_rd;
    logic [63:0] mul_product;
    logic [31:0] div_quot, div_rem, pipe_wb_data;
    logic        rf_we, busy_clr_valid, mdu_stall, pipe_hold, err_overflow;
    logic [4:0]  rf_waddr, busy_clr_rd;
    logic [31:0] rf_wdata;

    int total = 0;
    int bad   = 0;

    wire [43:0] wb = {rf_we, rf_waddr, rf_wdata, busy_clr_valid, busy_clr_rd};
    wire [2:0]  fl = {mdu_stall, pipe_hold, err_overflow};

    mdu_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .DATA_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .mul_done_valid  (mul_done_valid),
        .mul_done_funct3 (mul_done_funct3),
        .mul_done_rd     (mul_done_rd),
        .mul_product     (mul_product),
        .div_done_valid  (div_done_valid),
        .div_done_funct3 (div_done_funct3),
        .div_done_rd     (div_done_rd),
        .div_quot        (div_quot),
        .div_rem         (div_rem),
        .pipe_wb_en      (pipe_wb_en),
        .pipe_wb_rd      (pipe_wb_rd),
        .pipe_wb_data    (pipe_wb_data),
        .rf_we           (rf_we),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .busy_clr_valid  (busy_clr_valid),
        .busy_clr_rd     (busy_clr_rd),
        .mdu_stall       (mdu_stall),
        .pipe_hold       (pipe_hold),
        .err_overflow    (err_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        mul_done_valid = 0; mul_done_funct3 = 0; mul_done_rd = 0; mul_product = 0;
        div_done_valid = 0; div_done_funct3 = 0; div_done_rd = 0; div_quot = 0; div_rem = 0;
        pipe_wb_en = 0; pipe_wb_rd = 0; pipe_wb_data = 0;
    endtask

    task automatic do_reset;
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        total++; if (wb !== 44'd0) begin bad++; $display("FAIL reset_wb got=%h want=%h", wb, 44'd0); end
        total++; if (fl !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", fl); end
        tick();
        total++; if (wb !== 44'd0 || fl !== 3'b000) begin bad++; $display("FAIL reset_idle got=%h/%b want=0/000", wb, fl); end
    endtask

    task automatic test_bypass;
        do_reset();
        mul_done_valid = 1; mul_done_funct3 = 3'b001; mul_done_rd = 5; mul_product = 64'h0000_0003_0000_0007;
        #1;
        total++; if (wb !== {1'b1, 5'd5, 32'h3, 1'b1, 5'd5}) begin bad++; $display("FAIL byp_mulh got=%h want=%h", wb, {1'b1, 5'd5, 32'h3, 1'b1, 5'd5}); end
        mul_done_funct3 = 3'b000;
        #1;
        total++; if (wb !== {1'b1, 5'd5, 32'h7, 1'b1, 5'd5}) begin bad++; $display("FAIL byp_mul got=%h want=%h", wb, {1'b1, 5'd5, 32'h7, 1'b1, 5'd5}); end
        idle();
        div_done_valid = 1; div_done_funct3 = 3'b101; div_done_rd = 6; div_quot = 32'hdead; div_rem = 32'hbeef;
        #1;
        total++; if (wb !== {1'b1, 5'd6, 32'hdead, 1'b1, 5'd6}) begin bad++; $display("FAIL byp_div got=%h want=%h", wb, {1'b1, 5'd6, 32'hdead, 1'b1, 5'd6}); end
        tick();
        idle();
        #1;
        total++; if (wb !== 44'd0 || fl !== 3'b000) begin bad++; $display("FAIL byp_after got=%h/%b want=0/000", wb, fl); end
    endtask

    task automatic test_dual;
        do_reset();
        mul_done_valid = 1; mul_done_funct3 = 3'b000; mul_done_rd = 3; mul_product = 64'h1_0000_0042;
        div_done_valid = 1; div_done_funct3 = 3'b110; div_done_rd = 4; div_rem = 9; div_quot = 5;
        #1;
        total++; if (wb !== {1'b1, 5'd3, 32'h42, 1'b1, 5'd3}) begin bad++; $display("FAIL dual_c0 got=%h want=%h", wb, {1'b1, 5'd3, 32'h42, 1'b1, 5'd3}); end
        tick();
        idle();
        #1;
        total++; if (wb !== {1'b1, 5'd4, 32'd9, 1'b1, 5'd4}) begin bad++; $display("FAIL dual_c1 got=%h want=%h", wb, {1'b1, 5'd4, 32'd9, 1'b1, 5'd4}); end
        total++; if (mdu_stall !== 1'b0) begin bad++; $display("FAIL dual_stall got=%b want=0", mdu_stall); end
        tick();
        total++; if (wb !== 44'd0) begin bad++; $display("FAIL dual_c2 got=%h want=0", wb); end
    endtask

    task automatic test_starve;
        int pulses = 0;
        do_reset();
        pipe_wb_en = 1; pipe_wb_rd = 7; pipe_wb_data = 32'h77;
        mul_done_valid = 1; mul_done_funct3 = 3'b011; mul_done_rd = 9; mul_product = 64'hABCD_0000_0000_0001;
        #1;
        total++; if (wb !== {1'b1, 5'd7, 32'h77, 1'b0, 5'd0}) begin bad++; $display("FAIL starve_pipe got=%h want=%h", wb, {1'b1, 5'd7, 32'h77, 1'b0, 5'd0}); end
        tick();
        mul_done_valid = 0;
        for (int k = 1; k <= LIMIT; k++) begin
            #1;
            total++; if (pipe_hold !== 1'b0) begin bad++; $display("FAIL starve_early k=%0d got=%b want=0", k, pipe_hold); end
            pulses += int'(busy_clr_valid);
            tick();
        end
        #1;
        total++; if (pipe_hold !== 1'b1) begin bad++; $display("FAIL starve_hold got=%b want=1", pipe_hold); end
        pulses += int'(busy_clr_valid);
        tick();
        pipe_wb_en = 0;
        #1;
        total++; if (wb !== {1'b1, 5'd9, 32'hABCD_0000, 1'b1, 5'd9}) begin bad++; $display("FAIL starve_drain got=%h want=%h", wb, {1'b1, 5'd9, 32'hABCD_0000, 1'b1, 5'd9}); end
        total++; if (pipe_hold !== 1'b0) begin bad++; $display("FAIL starve_pulse got=%b want=0", pipe_hold); end
        pulses += int'(busy_clr_valid);
        tick();
        pulses += int'(busy_clr_valid);
        total++; if (pulses != 1) begin bad++; $display("FAIL starve_clr_count got=%0d want=1", pulses); end
    endtask

    task automatic test_fill;
        logic [4:0]  erd [4]  = '{5'd1, 5'd2, 5'd3, 5'd4};
        logic [31:0] edat [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        do_reset();
        pipe_wb_en = 1; pipe_wb_rd = 1; pipe_wb_data = 32'h1000;
        mul_done_valid = 1; mul_done_funct3 = 3'b000; mul_done_rd = 1; mul_product = 64'h11;
        div_done_valid = 1; div_done_funct3 = 3'b100; div_done_rd = 2; div_quot = 32'h22;
        tick();
        total++; if (mdu_stall !== 1'b0) begin bad++; $display("FAIL fill_occ2 got=%b want=0", mdu_stall); end
        div_done_valid = 0; mul_done_rd = 3; mul_product = 64'h33;
        tick();
        total++; if (fl !== 3'b100) begin bad++; $display("FAIL fill_occ3 got=%b want=100", fl); end
        mul_done_valid = 0; div_done_valid = 1; div_done_rd = 4; div_quot = 32'h44;
        tick();
        total++; if (fl !== 3'b100) begin bad++; $display("FAIL fill_occ4 got=%b want=100", fl); end
        div_done_valid = 0; mul_done_valid = 1; mul_done_rd = 5; mul_product = 64'h55;
        #1;
        total++; if (wb !== {1'b1, 5'd1, 32'h1000, 1'b0, 5'd0}) begin bad++; $display("FAIL fill_pipe got=%h want=%h", wb, {1'b1, 5'd1, 32'h1000, 1'b0, 5'd0}); end
        tick();
        total++; if (fl !== 3'b101) begin bad++; $display("FAIL fill_overflow got=%b want=101", fl); end
        idle();
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (wb !== {1'b1, erd[i], edat[i], 1'b1, erd[i]}) begin bad++; $display("FAIL fill_drain%0d got=%h want=%h", i, wb, {1'b1, erd[i], edat[i], 1'b1, erd[i]}); end
            tick();
            total++; if (mdu_stall !== (i == 0)) begin bad++; $display("FAIL fill_stall%0d got=%b want=%b", i, mdu_stall, i == 0); end
        end
        #1;
        total++; if (wb !== 44'd0 || err_overflow !== 1'b1) begin bad++; $display("FAIL fill_end got=%h/%b want=0/1", wb, err_overflow); end
    endtask

    task automatic test_rd0;
        do_reset();
        mul_done_valid = 1; mul_done_rd = 0; mul_product = 64'h5;
        div_done_valid = 1; div_done_rd = 0; div_done_funct3 = 3'b100; div_quot = 32'h6;
        #1;
        total++; if (wb !== 44'd0) begin bad++; $display("FAIL rd0_bypass got=%h want=0", wb); end
        tick();
        idle();
        pipe_wb_en = 1; pipe_wb_rd = 2; mul_done_valid = 1; mul_done_rd = 8; mul_product = 64'h88;
        tick();
        mul_done_rd = 0; div_done_valid = 1; div_done_rd = 0; div_done_funct3 = 3'b100;
        tick();
        idle();
        #1;
        total++; if (wb !== {1'b1, 5'd8, 32'h88, 1'b1, 5'd8}) begin bad++; $display("FAIL rd0_head got=%h want=%h", wb, {1'b1, 5'd8, 32'h88, 1'b1, 5'd8}); end
        tick();
        total++; if (wb !== 44'd0 || fl !== 3'b000) begin bad++; $display("FAIL rd0_empty got=%h/%b want=0/000", wb, fl); end
    endtask

    task automatic test_reset_flush;
        do_reset();
        pipe_wb_en = 1; pipe_wb_rd = 1;
        mul_done_valid = 1; mul_done_rd = 10; div_done_valid = 1; div_done_rd = 11; div_done_funct3 = 3'b100;
        tick();
        div_done_valid = 0; mul_done_rd = 12;
        tick();
        total++; if (mdu_stall !== 1'b1) begin bad++; $display("FAIL flush_stall got=%b want=1", mdu_stall); end
        idle();
        rst = 1;
        #1;
        total++; if (wb !== 44'd0) begin bad++; $display("FAIL flush_during got=%h want=0", wb); end
        tick();
        rst = 0;
        #1;
        total++; if (wb !== 44'd0 || fl !== 3'b000) begin bad++; $display("FAIL flush_after got=%h/%b want=0/000", wb, fl); end
        tick();
        total++; if (wb !== 44'd0) begin bad++; $display("FAIL flush_next got=%h want=0", wb); end
    endtask

    function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [63:0] p);
        return (f == 3'b000) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] q, input logic [31:0] r);
        return (f == 3'b100 || f == 3'b101) ? q : r;
    endfunction

    task automatic test_random;
        logic [36:0] q[$];
        int          cnt = 0;
        logic        e_err = 0, e_stall = 0, e_hold = 0;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            logic        mr, dr, deq;
            logic [31:0] md, dd;
            logic [43:0] exp;
            int          sz0, byp, ppct, apct;
            ppct = (n < 400) ? 45 : 85;
            apct = (n < 400) ? 30 : 20;
            pipe_wb_en      = e_hold ? 1'b0 : ($urandom_range(0, 99) < ppct);
            pipe_wb_rd      = 5'($urandom);
            pipe_wb_data    = $urandom;
            mul_done_valid  = $urandom_range(0, 99) < apct;
            mul_done_funct3 = 3'($urandom_range(0, 3));
            mul_done_rd     = ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom);
            mul_product     = {$urandom, $urandom};
            div_done_valid  = $urandom_range(0, 99) < apct;
            div_done_funct3 = 3'($urandom_range(4, 7));
            div_done_rd     = ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom);
            div_quot        = $urandom;
            div_rem         = $urandom;
            mr = mul_done_valid && mul_done_rd != 0;
            dr = div_done_valid && div_done_rd != 0;
            md = ref_mul(mul_done_funct3, mul_product);
            dd = ref_div(div_done_funct3, div_quot, div_rem);
            sz0 = q.size();
            byp = 0;
            if (pipe_wb_en)   exp = {1'b1, pipe_wb_rd, pipe_wb_data, 1'b0, 5'd0};
            else if (sz0 > 0) exp = {1'b1, q[0][36:32], q[0][31:0], 1'b1, q[0][36:32]};
            else if (mr)      begin exp = {1'b1, mul_done_rd, md, 1'b1, mul_done_rd}; byp = 1; end
            else if (dr)      begin exp = {1'b1, div_done_rd, dd, 1'b1, div_done_rd}; byp = 2; end
            else              exp = 44'd0;
            #1;
            total++; if (wb !== exp) begin bad++; $display("FAIL rand_wb n=%0d got=%h want=%h", n, wb, exp); end
            deq = !pipe_wb_en && sz0 > 0;
            if (deq) void'(q.pop_front());
            if (mr && byp != 1) begin if (q.size() < DEPTH) q.push_back({mul_done_rd, md}); else e_err = 1; end
            if (dr && byp != 2) begin if (q.size() < DEPTH) q.push_back({div_done_rd, dd}); else e_err = 1; end
            e_stall = q.size() >= DEPTH - 1;
            if (sz0 == 0 || deq) begin
                cnt = 0; e_hold = 0;
            end else begin
                cnt++;
                e_hold = cnt == LIMIT;
                if (e_hold) cnt = 0;
            end
            tick();
            total++; if (fl !== {e_stall, e_hold, e_err}) begin bad++; $display("FAIL rand_flags n=%0d got=%b want=%b", n, fl, {e_stall, e_hold, e_err}); end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_bypass();
        test_dual();
        test_starve();
        test_fill();
        test_rd0();
        test_reset_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
